// File: rtl/calc_op_sequencer.sv
// Byte-serial sequencer between the I2C register front end and the calculator:
// collects op/A/B bytes, waits CALC_LAT cycles, then streams the 64-bit result out.
module calc_op_sequencer #(
  parameter int CALC_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        abort,
  output logic [31:0] calc_a,
  output logic [31:0] calc_b,
  output logic [1:0]  calc_op,
  input  logic [63:0] calc_result,
  output logic        busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LD_A = 3'd1;
  localparam logic [2:0] S_LD_B = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  localparam logic [3:0] LAT_END = 4'(CALC_LAT);

  logic [2:0]  state_q, state_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;
  logic [31:0] calc_a_q, calc_a_d;
  logic [31:0] calc_b_q, calc_b_d;
  logic [1:0]  calc_op_q, calc_op_d;
  logic [63:0] result_q, result_d;

  logic in_fire;
  logic out_fire;

  // Handshake outputs depend on registered state only.
  assign in_ready  = (state_q == S_IDLE) || (state_q == S_LD_A) || (state_q == S_LD_B);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = result_q[{byte_cnt_q, 3'b000} +: 8];
  assign calc_a    = calc_a_q;
  assign calc_b    = calc_b_q;
  assign calc_op   = calc_op_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    calc_a_d   = calc_a_q;
    calc_b_d   = calc_b_q;
    calc_op_d  = calc_op_q;
    result_d   = result_q;

    // Abort wins over any transfer in the same cycle; operands are kept.
    if (abort) begin
      state_d    = S_IDLE;
      byte_cnt_d = 3'd0;
      lat_cnt_d  = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_fire) begin
            calc_op_d  = in_data[1:0];
            byte_cnt_d = 3'd0;
            state_d    = S_LD_A;
          end
        end
        S_LD_A: begin
          if (in_fire) begin
            calc_a_d[{byte_cnt_q[1:0], 3'b000} +: 8] = in_data;
            if (byte_cnt_q == 3'd3) begin
              byte_cnt_d = 3'd0;
              state_d    = S_LD_B;
            end else begin
              byte_cnt_d = byte_cnt_q + 3'd1;
            end
          end
        end
        S_LD_B: begin
          if (in_fire) begin
            calc_b_d[{byte_cnt_q[1:0], 3'b000} +: 8] = in_data;
            if (byte_cnt_q == 3'd3) begin
              byte_cnt_d = 3'd0;
              lat_cnt_d  = 4'd0;
              state_d    = S_EXEC;
            end else begin
              byte_cnt_d = byte_cnt_q + 3'd1;
            end
          end
        end
        S_EXEC: begin
          // Counter starts at 0, so EXEC spans CALC_LAT+1 cycles.
          if (lat_cnt_q == LAT_END) begin
            result_d   = calc_result;
            byte_cnt_d = 3'd0;
            state_d    = S_OUT;
          end else begin
            lat_cnt_d = lat_cnt_q + 4'd1;
          end
        end
        S_OUT: begin
          if (out_fire) begin
            if (byte_cnt_q == 3'd7) begin
              byte_cnt_d = 3'd0;
              state_d    = S_IDLE;
            end else begin
              byte_cnt_d = byte_cnt_q + 3'd1;
            end
          end
        end
        default: begin
          state_d    = S_IDLE;
          byte_cnt_d = 3'd0;
          lat_cnt_d  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 3'd0;
      lat_cnt_q  <= 4'd0;
      calc_a_q   <= 32'd0;
      calc_b_q   <= 32'd0;
      calc_op_q  <= 2'd0;
      result_q   <= 64'd0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      calc_a_q   <= calc_a_d;
      calc_b_q   <= calc_b_d;
      calc_op_q  <= calc_op_d;
      result_q   <= result_d;
    end
  end

endmodule

// File: doc/calc_op_sequencer.md
CALC_OP_SEQUENCER -- requirements
Module: calc_op_sequencer

Interface
REQ-001 SHALL have parameter CALC_LAT, default 2, meaning the number of cycles from operand/op settle to calc_result being valid (range 1..15).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_data  input  8  command/operand byte from the I2C register front end.
REQ-005 SHALL have port in_valid  input  1  in_data valid.
REQ-006 SHALL have port in_ready  output  1  sequencer accepts a byte; transfer occurs when in_valid and in_ready are both high on a clk edge.
REQ-007 SHALL have port out_data  output  8  result byte to the I2C front end.
REQ-008 SHALL have port out_valid  output  1  out_data valid.
REQ-009 SHALL have port out_ready  input  1  consumer takes a byte; transfer occurs when out_valid and out_ready are both high.
REQ-010 SHALL have port abort  input  1  synchronous abort of the current transaction.
REQ-011 SHALL have port calc_a  output  32  first operand to calculator.
REQ-012 SHALL have port calc_b  output  32  second operand to calculator.
REQ-013 SHALL have port calc_op  output  2  operation code to calculator.
REQ-014 SHALL have port calc_result  input  64  calculator result.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, LD_A, LD_B, EXEC, OUT; one 3-bit byte counter, one 4-bit latency counter.
REQ-017 IDLE: in_ready=1; accepted byte -> calc_op <= in_data[1:0] (bits 7:2 ignored), byte counter <= 0, next state LD_A.
REQ-018 LD_A: in_ready=1; each accepted byte written to calc_a byte lane [counter], little-endian (first byte = bits 7:0); after 4th byte -> LD_B, counter <= 0.
REQ-019 LD_B: same as LD_A into calc_b; after 4th byte -> EXEC, latency counter <= 0.
REQ-020 Cycles with in_valid=0 in IDLE/LD_A/LD_B SHALL hold state, counters and operands (no timeout).
REQ-021 EXEC: in_ready=0; latency counter increments each cycle; when counter reaches CALC_LAT, calc_result SHALL be captured into a 64-bit result register and state -> OUT, byte counter <= 0; EXEC therefore lasts CALC_LAT+1 cycles.
REQ-022 calc_a, calc_b, calc_op SHALL remain stable from end of LD_B until next op byte is accepted in IDLE.
REQ-023 OUT: out_valid=1, out_data = result register byte [counter], little-endian; counter advances only on out_valid&out_ready; out_data SHALL not change while out_valid=1 and out_ready=0.
REQ-024 After 8th byte transfer -> IDLE; out_valid SHALL be 0 in the following cycle.
REQ-025 out_valid SHALL be 0 and in_ready SHALL be 0 in EXEC and OUT; in_valid in those states SHALL be ignored (no byte consumed).
REQ-026 abort=1 in any state SHALL force IDLE on the next edge, clear counters and out_valid; calc_a/calc_b/calc_op retain values; abort has priority over any simultaneous in/out transfer (transfer not counted).
REQ-027 in_ready and out_valid SHALL be decoded from registered state only (no combinational path from in_valid/out_ready).
REQ-028 Arithmetic is performed solely by the calculator; the sequencer SHALL not alter calc_result bits.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, all counters 0, calc_a=0, calc_b=0, calc_op=0, result register 0, out_valid=0, busy=0; in_ready=1 from first edge after release.
REQ-030 Reset asserted mid-transaction (any state) SHALL discard the transaction; no output byte appears after release until a full new sequence completes.

Verification
REQ-031 Bytes 0x00,1C,00,00,00,04,00,00,00 back-to-back, bench calc model add, CALC_LAT=2 -> calc_a=28, calc_b=4, calc_op=0; 3 EXEC cycles; out bytes 0x20,00,00,00,00,00,00,00.
REQ-032 Op 0x02, A=0xFFFFFFFF, B=0x00000002, mul model -> out bytes FE,FF,FF,FF,01,00,00,00; out_ready toggled 1/0 each cycle -> each byte held stable while stalled, exactly 8 transfers.
REQ-033 in_valid gaps of 3 cycles between every operand byte -> identical result to REQ-031; in_valid asserted during EXEC/OUT -> in_ready=0, no byte consumed.
REQ-034 abort pulsed after 2nd calc_b byte, then full new sequence op 0x01, A=10, B=3 -> sub result 7; busy low one cycle after abort.
REQ-035 rst_n pulsed low during OUT after 3 bytes read -> out_valid=0 immediately, all outputs at reset values, busy=0.
REQ-036 Op byte 0xFD -> calc_op=1 (upper bits ignored); CALC_LAT=1 build -> EXEC lasts 2 cycles.
